// File: rtl/kalman_dac_pkg.sv
// Shared widths, saturation limits, sequencer types and the DAC code mapping
// for the kalman_dac_tx output stage.
package kalman_dac_pkg;

  localparam int DAC_W   = 14;
  localparam int IN_W    = 16;
  localparam int SAT_MAX = 8191;
  localparam int SAT_MIN = -8192;

  typedef enum logic [1:0] {PH_A_SET, PH_A_WR, PH_B_SET, PH_B_WR} phase_e;
  typedef enum logic       {RST_HOLD, RUN} state_e;

  // Offset-binary style mapping: 0 -> 1FFF, +max -> 0000, -max -> 3FFF.
  function automatic logic [DAC_W-1:0] dac_code(input logic signed [DAC_W-1:0] v);
    return {v[DAC_W-1], ~v[DAC_W-2:0]};
  endfunction

endpackage

// File: rtl/kalman_dac_chan.sv
// One DAC channel: arithmetic shift, clamp to 14-bit signed, hold register,
// staleness watchdog and sticky saturation flag.
module kalman_dac_chan
  import kalman_dac_pkg::*;
#(
  parameter int SHIFT        = 1,
  parameter int STALE_CYCLES = 1024
) (
  input  logic                    Clk,
  input  logic                    Rstn,
  input  logic [IN_W-1:0]         dat_i,
  input  logic                    vld_i,
  input  logic                    sat_clr_i,
  output logic signed [DAC_W-1:0] hold_o,
  output logic                    sat_o,
  output logic                    stale_o
);

  localparam int CW = $clog2(STALE_CYCLES + 1);
  localparam logic signed [IN_W-1:0] HI = IN_W'(SAT_MAX);
  localparam logic signed [IN_W-1:0] LO = IN_W'(SAT_MIN);

  logic signed [IN_W-1:0]  s;
  logic signed [DAC_W-1:0] clamped;
  logic                    clip;
  logic [CW-1:0]           cnt_q;
  logic signed [DAC_W-1:0] hold_q;
  logic                    sat_q, sat_d, stale_q;

  assign s = $signed(dat_i) >>> SHIFT;

  always_comb begin
    clip    = 1'b1;
    clamped = $signed(s[DAC_W-1:0]);
    if (s > HI)      clamped = DAC_W'(SAT_MAX);
    else if (s < LO) clamped = DAC_W'(SAT_MIN);
    else             clip    = 1'b0;
  end

  // A new clip in the same cycle as a clear keeps the flag set.
  assign sat_d = (sat_q & ~sat_clr_i) | (vld_i & clip);

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      cnt_q   <= '0;
      hold_q  <= '0;
      sat_q   <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
      if (vld_i) begin
        hold_q  <= clamped;
        cnt_q   <= '0;
        stale_q <= 1'b0;
      end else if (cnt_q != CW'(STALE_CYCLES)) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CW'(STALE_CYCLES - 1)) begin
          hold_q  <= '0;
          stale_q <= 1'b1;
        end
      end
    end
  end

  assign hold_o  = hold_q;
  assign sat_o   = sat_q;
  assign stale_o = stale_q;

endmodule

// File: rtl/kalman_dac_tx.sv
// Interleaved two-channel 14-bit DAC driver: reset hold, then a 4-phase A/B write
// sequencer. Define KDAC_RAMP_TEST_EN to replace channel B with an internal ramp.
module kalman_dac_tx
  import kalman_dac_pkg::*;
#(
  parameter int SHIFT        = 1,
  parameter int STALE_CYCLES = 1024,
  parameter int RST_CYCLES   = 16
) (
  input  logic             Clk,
  input  logic             Rstn,
  input  logic [IN_W-1:0]  ch_a_dat,
  input  logic             ch_a_vld,
  input  logic [IN_W-1:0]  ch_b_dat,
  input  logic             ch_b_vld,
  input  logic             sat_clr,
  output logic [DAC_W-1:0] dac_dat_o,
  output logic             dac_sel_o,
  output logic             dac_wrt_o,
  output logic             dac_rst_o,
  output logic [1:0]       sat_o,
  output logic [1:0]       stale_o
);

  localparam int RCW = $clog2(RST_CYCLES + 1);

  logic signed [DAC_W-1:0] hold_a, hold_b, frame_b_q;
  logic                    sat_a, stale_a;
  state_e                  state_q;
  phase_e                  phase_q;
  logic [RCW-1:0]          rcnt_q;

  kalman_dac_chan #(.SHIFT(SHIFT), .STALE_CYCLES(STALE_CYCLES)) u_chan_a (
    .Clk(Clk), .Rstn(Rstn), .dat_i(ch_a_dat), .vld_i(ch_a_vld), .sat_clr_i(sat_clr),
    .hold_o(hold_a), .sat_o(sat_a), .stale_o(stale_a)
  );

`ifdef KDAC_RAMP_TEST_EN
  logic signed [DAC_W-1:0] ramp_q;

  // Ramp advances once per frame, wrapping naturally at 14 bits.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn)                                     ramp_q <= '0;
    else if (state_q == RUN && phase_q == PH_A_SET) ramp_q <= ramp_q + 1'b1;
  end

  assign hold_b  = ramp_q;
  assign sat_o   = {1'b0, sat_a};
  assign stale_o = {1'b0, stale_a};
`else
  logic sat_b, stale_b;

  kalman_dac_chan #(.SHIFT(SHIFT), .STALE_CYCLES(STALE_CYCLES)) u_chan_b (
    .Clk(Clk), .Rstn(Rstn), .dat_i(ch_b_dat), .vld_i(ch_b_vld), .sat_clr_i(sat_clr),
    .hold_o(hold_b), .sat_o(sat_b), .stale_o(stale_b)
  );

  assign sat_o   = {sat_b, sat_a};
  assign stale_o = {stale_b, stale_a};
`endif

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state_q   <= RST_HOLD;
      rcnt_q    <= '0;
      phase_q   <= PH_A_SET;
      frame_b_q <= '0;
      dac_dat_o <= 14'h1FFF;
      dac_sel_o <= 1'b0;
      dac_wrt_o <= 1'b0;
      dac_rst_o <= 1'b1;
    end else begin
      case (state_q)
        RST_HOLD: begin
          if (rcnt_q == RCW'(RST_CYCLES - 1)) begin
            state_q   <= RUN;
            dac_rst_o <= 1'b0;
            phase_q   <= PH_A_SET;
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        RUN: begin
          phase_q <= phase_e'(phase_q + 2'd1);
          case (phase_q)
            // A and B are sampled together so a frame is coherent.
            PH_A_SET: begin
              frame_b_q <= hold_b;
              dac_sel_o <= 1'b1;
              dac_dat_o <= dac_code(hold_a);
              dac_wrt_o <= 1'b0;
            end
            PH_A_WR:  dac_wrt_o <= 1'b1;
            PH_B_SET: begin
              dac_sel_o <= 1'b0;
              dac_dat_o <= dac_code(frame_b_q);
              dac_wrt_o <= 1'b0;
            end
            PH_B_WR:  dac_wrt_o <= 1'b1;
            default:  dac_wrt_o <= 1'b0;
          endcase
        end
        default: state_q <= RST_HOLD;
      endcase
    end
  end

endmodule
